// File: rtl/led_pattern_sequencer.sv
// Pattern-table sequencer for the 8-LED PWM bank.
// It walks four {mask, level, hold} entries and ramps brightness one step per tick toward each entry's level.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | outputs parked at zero, waiting for start
//   ST_RAMP | stepping brightness toward tgt, one step per tick
//   ST_HOLD | brightness at tgt, counting hold_cnt down to zero
module led_pattern_sequencer #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_mask,
    input  logic [7:0]  cfg_level,
    input  logic [15:0] cfg_hold,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic        busy,
    output logic [1:0]  step_idx,
    output logic [7:0]  led_mask,
    output logic [7:0]  brightness,
    output logic        done
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_HOLD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tbl_mask_q  [4];
    logic [7:0]    tbl_mask_d  [4];
    logic [7:0]    tbl_level_q [4];
    logic [7:0]    tbl_level_d [4];
    logic [15:0]   tbl_hold_q  [4];
    logic [15:0]   tbl_hold_d  [4];
    logic [7:0]    tgt_q, tgt_d;
    logic [15:0]   hold_w_q, hold_w_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic          busy_q, busy_d;
    logic [1:0]    step_idx_q, step_idx_d;
    logic [7:0]    led_mask_q, led_mask_d;
    logic [7:0]    brightness_q, brightness_d;
    logic          done_q, done_d;

    logic       tick;
    logic       load;
    logic [1:0] load_idx;
    logic       go_idle;
    logic       accept;
    logic [7:0] br_next;

    assign tick = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);

    always_comb begin
        tbl_mask_d  = tbl_mask_q;
        tbl_level_d = tbl_level_q;
        tbl_hold_d  = tbl_hold_q;
        if (cfg_we) begin
            tbl_mask_d[cfg_addr]  = cfg_mask;
            tbl_level_d[cfg_addr] = cfg_level;
            tbl_hold_d[cfg_addr]  = cfg_hold;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_idx_d   = step_idx_q;
        led_mask_d   = led_mask_q;
        brightness_d = brightness_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tgt_d        = tgt_q;
        hold_w_d     = hold_w_q;
        hold_cnt_d   = hold_cnt_q;
        load         = 1'b0;
        load_idx     = step_idx_q;
        go_idle      = 1'b0;
        accept       = 1'b0;
        br_next      = brightness_q;

        case (state_q)
            ST_IDLE: begin
                led_mask_d   = '0;
                brightness_d = '0;
                busy_d       = 1'b0;
                step_idx_d   = '0;
                if (start && !stop) begin
                    accept   = 1'b1;
                    load     = 1'b1;
                    load_idx = 2'd0;
                end
            end
            ST_RAMP: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (tick) begin
                    if (brightness_q != tgt_q) begin
                        br_next      = (brightness_q < tgt_q) ? brightness_q + 8'd1
                                                              : brightness_q - 8'd1;
                        brightness_d = br_next;
                    end
                    // Already at target still costs one tick before HOLD.
                    if (br_next == tgt_q) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = hold_w_q;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (tick) begin
                    if (hold_cnt_q == '0) begin
                        if (step_idx_q != 2'd3 || loop_en) begin
                            load     = 1'b1;
                            load_idx = step_idx_q + 2'd1;
                        end else begin
                            go_idle = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        // Entry is latched into working registers so later table writes do not disturb it.
        if (load) begin
            state_d    = ST_RAMP;
            step_idx_d = load_idx;
            led_mask_d = tbl_mask_q[load_idx];
            tgt_d      = tbl_level_q[load_idx];
            hold_w_d   = tbl_hold_q[load_idx];
            busy_d     = 1'b1;
        end
        if (go_idle) begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            step_idx_d   = '0;
            led_mask_d   = '0;
            brightness_d = '0;
        end

        if (accept || state_d == ST_IDLE || tick) presc_d = '0;
        else                                      presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            tgt_q        <= '0;
            hold_w_q     <= '0;
            hold_cnt_q   <= '0;
            busy_q       <= 1'b0;
            step_idx_q   <= '0;
            led_mask_q   <= '0;
            brightness_q <= '0;
            done_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tbl_mask_q[i]  <= '0;
                tbl_level_q[i] <= '0;
                tbl_hold_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tgt_q        <= tgt_d;
            hold_w_q     <= hold_w_d;
            hold_cnt_q   <= hold_cnt_d;
            busy_q       <= busy_d;
            step_idx_q   <= step_idx_d;
            led_mask_q   <= led_mask_d;
            brightness_q <= brightness_d;
            done_q       <= done_d;
            tbl_mask_q   <= tbl_mask_d;
            tbl_level_q  <= tbl_level_d;
            tbl_hold_q   <= tbl_hold_d;
        end
    end

    assign busy       = busy_q;
    assign step_idx   = step_idx_q;
    assign led_mask   = led_mask_q;
    assign brightness = brightness_q;
    assign done       = done_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: per-cycle expected outputs from a tick/phase-level reference model,
// queued by the driver and popped/compared by an independent monitor.
module tb_led_pattern_sequencer;
    localparam int CLK_FREQ = 100;
    localparam int TICK_HZ  = 10;
    localparam int DIV      = CLK_FREQ / TICK_HZ;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [7:0]  cfg_mask = '0;
    logic [7:0]  cfg_level = '0;
    logic [15:0] cfg_hold = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        busy;
    logic [1:0]  step_idx;
    logic [7:0]  led_mask;
    logic [7:0]  brightness;
    logic        done;

    led_pattern_sequencer #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_level(cfg_level), .cfg_hold(cfg_hold),
        .start(start), .stop(stop), .loop_en(loop_en), .busy(busy),
        .step_idx(step_idx), .led_mask(led_mask), .brightness(brightness), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [1:0] idx;
        logic [7:0] mask;
        logic [7:0] br;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: table, plus "active" flag, ticks left in ramp and hold phases.
    int t_mask[4], t_level[4], t_hold[4];
    bit m_act;
    int m_idx, m_mask, m_br, m_tgt, m_hold, m_div, m_ramp_left, m_hold_left;
    bit m_done;

    task automatic m_load(input int e);
        int d;
        m_idx  = e;
        m_mask = t_mask[e];
        m_tgt  = t_level[e];
        m_hold = t_hold[e];
        d = m_tgt - m_br;
        if (d < 0) d = -d;
        m_ramp_left = (d == 0) ? 1 : d;
        m_hold_left = 0;
    endtask

    task automatic m_tick();
        if (m_ramp_left > 0) begin
            if (m_br < m_tgt) m_br++;
            else if (m_br > m_tgt) m_br--;
            m_ramp_left--;
            if (m_ramp_left == 0) m_hold_left = m_hold + 1;
        end else begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                if (m_idx < 3 || loop_en) m_load((m_idx + 1) % 4);
                else begin
                    m_act = 0; m_done = 1; m_idx = 0; m_mask = 0; m_br = 0;
                end
            end
        end
    endtask

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin t_mask[i] = 0; t_level[i] = 0; t_hold[i] = 0; end
            m_act = 0; m_idx = 0; m_mask = 0; m_br = 0; m_tgt = 0; m_hold = 0;
            m_div = 0; m_ramp_left = 0; m_hold_left = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (start && !stop) begin
                    m_act = 1; m_div = 0; m_br = 0;
                    m_load(0);
                end
            end else if (stop) begin
                m_act = 0; m_idx = 0; m_mask = 0; m_br = 0;
            end else if (m_div == DIV - 1) begin
                m_div = 0;
                m_tick();
            end else begin
                m_div++;
            end
            if (cfg_we) begin
                t_mask[cfg_addr]  = int'(cfg_mask);
                t_level[cfg_addr] = int'(cfg_level);
                t_hold[cfg_addr]  = int'(cfg_hold);
            end
        end
        e.busy = m_act;
        e.idx  = 2'(m_idx);
        e.mask = 8'(m_mask);
        e.br   = 8'(m_br);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    // One clock: predict post-edge outputs, let the edge happen, release pulses.
    task automatic cyc();
        model_step();
        @(negedge clk);
        #1;
        cfg_we = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int a, input int m, input int l, input int h);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_mask = 8'(m); cfg_level = 8'(l); cfg_hold = 16'(h);
        cyc();
    endtask

    task automatic prog_base();
        wr(0, 8'h55, 3, 2);
        wr(1, 8'hAA, 0, 0);
        wr(2, 8'h0F, 0, 0);
        wr(3, 8'hF0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (busy !== e.busy || led_mask !== e.mask || brightness !== e.br || done !== e.done ||
                (e.busy && step_idx !== e.idx)) begin
                miscompares++;
                $display("FAIL outputs t=%0t got busy=%b idx=%0d mask=%h br=%0d done=%b expected busy=%b idx=%0d mask=%h br=%0d done=%b",
                         $time, busy, step_idx, led_mask, brightness, done,
                         e.busy, e.idx, e.mask, e.br, e.done);
            end
        end
    end

    initial begin
        @(negedge clk);
        #1;
        // Reset, then play the cleared table: 8 ticks of zeros, then done.
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        start = 1'b1; cyc();
        run(90);

        // Single pass with the base table.
        prog_base();
        loop_en = 1'b0;
        start = 1'b1; cyc();
        run(150);

        // Loop mode for three passes, then stop.
        loop_en = 1'b1;
        start = 1'b1; cyc();
        run(430);
        start = 1'b1; cyc();
        stop = 1'b1; cyc();
        run(5);

        // Stop coinciding with the first e0 HOLD tick; then start+stop in IDLE.
        loop_en = 1'b0;
        start = 1'b1; cyc();
        run(39);
        stop = 1'b1; cyc();
        run(3);
        start = 1'b1; stop = 1'b1; cyc();
        run(5);

        // Live write into the playing entry, observed after a loop wrap.
        loop_en = 1'b1;
        start = 1'b1; cyc();
        run(35);
        wr(0, 8'h55, 200, 2);
        run(400);
        stop = 1'b1; cyc();
        run(3);

        // Reset mid-ramp, then replay the cleared table.
        prog_base();
        loop_en = 1'b0;
        start = 1'b1; cyc();
        run(20);
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        start = 1'b1; cyc();
        run(90);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 999) != 0);
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_mask  = 8'($urandom_range(0, 255));
            cfg_level = 8'($urandom_range(0, 6));
            cfg_hold  = 16'($urandom_range(0, 3));
            start     = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) loop_en = 1'($urandom_range(0, 1));
            cyc();
        end
        rst_n = 1'b1;
        run(2);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
